// File: rtl/clock_mode_controller_if.sv
// Purpose: button inputs and BCD time / status outputs of clock_mode_controller.
// Modports: slave = controller side (buttons in, digits/status out);
//           master = button driver / display side. pm exists only with HOUR12_EN.
interface clock_mode_controller_if;
  logic       btn_mode;
  logic       btn_inc;
  logic [1:0] hr_tens;
  logic [3:0] hr_ones;
  logic [2:0] min_tens;
  logic [3:0] min_ones;
  logic [2:0] sec_tens;
  logic [3:0] sec_ones;
  logic [1:0] mode_state;
  logic       blink;
  logic       sec_pulse;
`ifdef HOUR12_EN
  logic       pm;
`endif

  modport slave (
    input  btn_mode, btn_inc,
    output hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones,
    output mode_state, blink, sec_pulse
`ifdef HOUR12_EN
    , output pm
`endif
  );

  modport master (
    output btn_mode, btn_inc,
    input  hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones,
    input  mode_state, blink, sec_pulse
`ifdef HOUR12_EN
    , input pm
`endif
  );
endinterface

// File: rtl/clock_mode_controller.sv
// Purpose: 1 s prescaler, BCD hh:mm:ss with cascaded carries, RUN/SET_HR/SET_MIN mode FSM.
// Ports: clk, reset (sync, active-high), bus (slave modport: btn_mode, btn_inc in;
//        BCD digits, mode_state, blink, sec_pulse out; pm out when HOUR12_EN is defined).
// Config: define HOUR12_EN for 12-hour operation (12,01..11 with pm flag); default is 24-hour.
module clock_mode_controller #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic                    clk,
  input  logic                    reset,
  clock_mode_controller_if.slave  bus
);
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {RUN = 2'b00, SET_HR = 2'b01, SET_MIN = 2'b10} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          mode_q, inc_q;
  logic [1:0]    ht, ht_nxt;
  logic [3:0]    ho, ho_nxt;
  logic [2:0]    mt, mt_nxt;
  logic [3:0]    mo, mo_nxt;
  logic [2:0]    st, st_nxt;
  logic [3:0]    so, so_nxt;
  logic          blink_r, blink_nxt;
  logic          pulse_r, pulse_nxt;
  logic          pm_r, pm_nxt;

  // Only rising edges act; a simultaneous mode rise swallows the inc rise.
  logic mode_rise, inc_rise, tick;
  assign mode_rise = bus.btn_mode & ~mode_q;
  assign inc_rise  = bus.btn_inc & ~inc_q & ~mode_rise;
  assign tick      = (cnt == CNT_MAX);

  logic sec_step, sec_wrap, min_step, hr_step;
  assign sec_step = (state == RUN) && tick;
  assign sec_wrap = sec_step && (so == 4'd9) && (st == 3'd5);
  assign min_step = sec_wrap || ((state == SET_MIN) && inc_rise);
  assign hr_step  = (sec_wrap && (mo == 4'd9) && (mt == 3'd5)) || ((state == SET_HR) && inc_rise);

  // Next hour value, per digit with explicit wrap.
  logic [1:0] hr_inc_t;
  logic [3:0] hr_inc_o;
  logic       pm_flip;
  always_comb begin
    hr_inc_t = ht;
    hr_inc_o = ho + 4'd1;
    pm_flip  = 1'b0;
`ifdef HOUR12_EN
    if (ht == 2'd1 && ho == 4'd1) begin
      pm_flip = 1'b1;                    // 11 -> 12 flips AM/PM
    end else if (ht == 2'd1 && ho == 4'd2) begin
      hr_inc_t = 2'd0;
      hr_inc_o = 4'd1;                   // 12 -> 01
    end else if (ho == 4'd9) begin
      hr_inc_t = ht + 2'd1;
      hr_inc_o = 4'd0;
    end
`else
    if (ht == 2'd2 && ho == 4'd3) begin
      hr_inc_t = 2'd0;
      hr_inc_o = 4'd0;                   // 23 -> 00
    end else if (ho == 4'd9) begin
      hr_inc_t = ht + 2'd1;
      hr_inc_o = 4'd0;
    end
`endif
  end

  // Next minute value; wrap 59 -> 00 (carry into hours handled by hr_step).
  logic [2:0] mi_inc_t;
  logic [3:0] mi_inc_o;
  always_comb begin
    mi_inc_t = mt;
    mi_inc_o = mo + 4'd1;
    if (mo == 4'd9) begin
      mi_inc_o = 4'd0;
      mi_inc_t = (mt == 3'd5) ? 3'd0 : mt + 3'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = tick ? '0 : cnt + CNT_ONE;
    ht_nxt    = ht;
    ho_nxt    = ho;
    mt_nxt    = mt;
    mo_nxt    = mo;
    st_nxt    = st;
    so_nxt    = so;
    pm_nxt    = pm_r;
    pulse_nxt = sec_step;
    blink_nxt = blink_r;

    case (state)
      RUN:     if (mode_rise) state_nxt = SET_HR;
      SET_HR:  if (mode_rise) state_nxt = SET_MIN;
      SET_MIN: if (mode_rise) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase

    if (sec_step) begin
      if (so == 4'd9) begin
        so_nxt = 4'd0;
        st_nxt = (st == 3'd5) ? 3'd0 : st + 3'd1;
      end else begin
        so_nxt = so + 4'd1;
      end
    end
    if (min_step) begin
      mt_nxt = mi_inc_t;
      mo_nxt = mi_inc_o;
    end
    if (hr_step) begin
      ht_nxt = hr_inc_t;
      ho_nxt = hr_inc_o;
      pm_nxt = pm_r ^ pm_flip;
    end

    // Leaving SET_MIN restarts the second from zero so the first advance is a full period later.
    if (state == SET_MIN && mode_rise) begin
      so_nxt  = 4'd0;
      st_nxt  = 3'd0;
      cnt_nxt = '0;
    end

    if (state_nxt == RUN)        blink_nxt = 1'b0;
    else if (state_nxt != state) blink_nxt = 1'b1;
    else if (tick)               blink_nxt = ~blink_r;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      cnt     <= '0;
      mode_q  <= 1'b1;                   // button held through reset yields no edge
      inc_q   <= 1'b1;
`ifdef HOUR12_EN
      ht      <= 2'd1;
      ho      <= 4'd2;
`else
      ht      <= 2'd0;
      ho      <= 4'd0;
`endif
      mt      <= 3'd0;
      mo      <= 4'd0;
      st      <= 3'd0;
      so      <= 4'd0;
      blink_r <= 1'b0;
      pulse_r <= 1'b0;
      pm_r    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      mode_q  <= bus.btn_mode;
      inc_q   <= bus.btn_inc;
      ht      <= ht_nxt;
      ho      <= ho_nxt;
      mt      <= mt_nxt;
      mo      <= mo_nxt;
      st      <= st_nxt;
      so      <= so_nxt;
      blink_r <= blink_nxt;
      pulse_r <= pulse_nxt;
      pm_r    <= pm_nxt;
    end
  end

  assign bus.hr_tens    = ht;
  assign bus.hr_ones    = ho;
  assign bus.min_tens   = mt;
  assign bus.min_ones   = mo;
  assign bus.sec_tens   = st;
  assign bus.sec_ones   = so;
  assign bus.mode_state = state;
  assign bus.blink      = blink_r;
  assign bus.sec_pulse  = pulse_r;
`ifdef HOUR12_EN
  assign bus.pm         = pm_r;
`endif
endmodule

// File: tb/tb_clock_mode_controller.sv
// Bench for clock_mode_controller with TICK_DIV=4: integer-time reference model
// compared every cycle, plus directed literal checks of key points.
module tb_clock_mode_controller;
  localparam int TD = 4;
`ifdef HOUR12_EN
  localparam int RST_H = 12, HR_PRESSES = 10, HR_MAX = 11, WRAP_H = 12;
`else
  localparam int RST_H = 0,  HR_PRESSES = 22, HR_MAX = 23, WRAP_H = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  clock_mode_controller_if bus ();
  clock_mode_controller #(.TICK_DIV(TD)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  // Reference model: time as plain integers, mode 0=RUN 1=SET_HR 2=SET_MIN.
  int m_h, m_m, m_s, m_mode, m_cnt;
  bit m_blink, m_pulse, m_pm, m_mq, m_iq;

  task automatic model_hr_inc();
`ifdef HOUR12_EN
    if (m_h == 11) begin m_h = 12; m_pm = !m_pm; end
    else if (m_h == 12) m_h = 1;
    else m_h++;
`else
    m_h = (m_h + 1) % 24;
`endif
  endtask

  always @(posedge clk) begin : model
    bit mr, ir, tk;
    if (reset) begin
      m_h = RST_H; m_m = 0; m_s = 0; m_mode = 0; m_cnt = 0;
      m_blink = 0; m_pulse = 0; m_pm = 0; m_mq = 1; m_iq = 1;
    end else begin
      mr = bus.btn_mode && !m_mq;
      ir = bus.btn_inc && !m_iq && !mr;
      tk = (m_cnt == TD - 1);
      m_cnt = tk ? 0 : m_cnt + 1;
      m_pulse = 0;
      if (m_mode == 0 && tk) begin
        m_pulse = 1;
        m_s++;
        if (m_s == 60) begin
          m_s = 0; m_m++;
          if (m_m == 60) begin m_m = 0; model_hr_inc(); end
        end
      end
      if (m_mode == 1 && ir) model_hr_inc();
      if (m_mode == 2 && ir) m_m = (m_m + 1) % 60;
      if (m_mode != 0 && tk) m_blink = !m_blink;
      if (mr) begin
        case (m_mode)
          0: begin m_mode = 1; m_blink = 1; end
          1: begin m_mode = 2; m_blink = 1; end
          default: begin m_mode = 0; m_blink = 0; m_s = 0; m_cnt = 0; end
        endcase
      end
      m_mq = bus.btn_mode;
      m_iq = bus.btn_inc;
    end
  end

  always @(negedge clk) begin
    bit ok;
    if (chk_en) begin
      n_checks++;
      ok = (int'(bus.hr_tens) == m_h / 10) && (int'(bus.hr_ones) == m_h % 10) &&
           (int'(bus.min_tens) == m_m / 10) && (int'(bus.min_ones) == m_m % 10) &&
           (int'(bus.sec_tens) == m_s / 10) && (int'(bus.sec_ones) == m_s % 10) &&
           (int'(bus.mode_state) == m_mode) && (bus.blink == m_blink) &&
           (bus.sec_pulse == m_pulse);
`ifdef HOUR12_EN
      ok = ok && (bus.pm == m_pm);
`endif
      if (!ok) begin
        n_err++;
        $display("FAIL cycle_model t=%0t got %0d%0d:%0d%0d:%0d%0d mode=%0d blink=%0d pulse=%0d exp %02d:%02d:%02d mode=%0d blink=%0d pulse=%0d",
                 $time, bus.hr_tens, bus.hr_ones, bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones,
                 bus.mode_state, bus.blink, bus.sec_pulse, m_h, m_m, m_s, m_mode, m_blink, m_pulse);
      end
    end
  end

  function automatic int now_time();
    return (int'(bus.hr_tens) * 10 + int'(bus.hr_ones)) * 10000 +
           (int'(bus.min_tens) * 10 + int'(bus.min_ones)) * 100 +
           int'(bus.sec_tens) * 10 + int'(bus.sec_ones);
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_mode();
    bus.btn_mode = 1'b1; step(1);
    bus.btn_mode = 1'b0; step(1);
  endtask

  task automatic press_inc(input int n);
    repeat (n) begin
      bus.btn_inc = 1'b1; step(1);
      bus.btn_inc = 1'b0; step(1);
    end
  endtask

  initial begin
    int pulses, first, last, gaps_ok;
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    step(1);
    chk_en = 1'b1;
    step(1);
    chk("rst_time", now_time(), RST_H * 10000);
    chk("rst_mode", int'(bus.mode_state), 0);
    chk("rst_blink_pulse", int'({bus.blink, bus.sec_pulse}), 0);
    reset = 1'b0;

    // Free run: advances at edges 4, 8, 12 after reset.
    pulses = 0; first = 0; last = 0; gaps_ok = 1;
    for (int i = 1; i <= 12; i++) begin
      step(1);
      if (bus.sec_pulse) begin
        if (first == 0) first = i;
        else if (i - last != TD) gaps_ok = 0;
        last = i;
        pulses++;
      end
    end
    chk("run_pulses", pulses, 3);
    chk("run_first_pulse", first, 4);
    chk("run_pulse_spacing", gaps_ok, 1);
    chk("run_time", now_time(), RST_H * 10000 + 3);

    // Simultaneous mode + inc rise in RUN: mode wins, time unchanged.
    bus.btn_mode = 1'b1; bus.btn_inc = 1'b1; step(1);
    chk("both_mode", int'(bus.mode_state), 1);
    chk("both_time", now_time(), RST_H * 10000 + 3);
    bus.btn_mode = 1'b0; bus.btn_inc = 1'b0; step(1);

    // 25 hour increments in SET_HR wrap past the top back to 01.
    pulses = 0;
    repeat (25) begin
      bus.btn_inc = 1'b1; step(1); if (bus.sec_pulse) pulses++;
      bus.btn_inc = 1'b0; step(1); if (bus.sec_pulse) pulses++;
    end
    chk("sethr_time", now_time(), 10000 + 3);
    chk("sethr_mode", int'(bus.mode_state), 1);
    chk("sethr_no_advance", pulses, 0);

    // Set HR_MAX:59, leave SET_MIN, run to the day/half-day boundary.
    press_inc(HR_PRESSES);
    press_mode();
    chk("setmin_mode", int'(bus.mode_state), 2);
    press_inc(59);
    bus.btn_mode = 1'b1; step(1);
    bus.btn_mode = 1'b0; step(1);
    chk("exit_time", now_time(), HR_MAX * 10000 + 5900);
    chk("exit_mode_blink", int'({bus.mode_state, bus.blink}), 0);
    step(235);
    chk("pre_wrap_time", now_time(), HR_MAX * 10000 + 5959);
    step(4);
    chk("wrap_time", now_time(), WRAP_H * 10000);
`ifdef HOUR12_EN
    chk("wrap_pm", int'(bus.pm), 1);
`endif

    // Run to :02, cycle modes, seconds cleared and next advance 4 cycles later.
    step(8);
    chk("run2_time", now_time(), WRAP_H * 10000 + 2);
    press_mode();
    press_mode();
    bus.btn_mode = 1'b1; step(1);
    chk("cycle_exit_time", now_time(), WRAP_H * 10000);
    chk("cycle_exit_mode", int'(bus.mode_state), 0);
    bus.btn_mode = 1'b0;
    first = 0;
    for (int i = 1; i <= 8; i++) begin
      step(1);
      if (bus.sec_pulse && first == 0) first = i;
    end
    chk("cycle_next_advance", first, 4);

    // Inc held through reset: no action until released and pressed again.
    bus.btn_inc = 1'b1; step(1);
    reset = 1'b1; step(2);
    chk("rst2_time", now_time(), RST_H * 10000);
    reset = 1'b0; step(1);
    press_mode();
    step(3);
    chk("held_no_inc", now_time(), RST_H * 10000);
    bus.btn_inc = 1'b0; step(1);
    bus.btn_inc = 1'b1; step(1);
    chk("reinc_time", now_time(), 10000);
    bus.btn_inc = 1'b0; step(2);

    // Reset while in SET_HR.
    reset = 1'b1; step(1);
    chk("rst_sethr_mode_blink", int'({bus.mode_state, bus.blink}), 0);
    reset = 1'b0; step(3);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
